// File: rtl/conv_row_writer.sv
// Sink-side row writer: takes the conv engine's output pixel stream and emits
// registered, linearly addressed writes into the output feature-map buffer.
module conv_row_writer #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 640,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [14:0]       row,
    output logic [14:0]       col,
    output logic              first_row,
    output logic              last_row,
    output logic              row_done,
    output logic              frame_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ROW_GAP,
        DONE
    } state_t;

    localparam logic [14:0]       LAST_COL = 15'(IMG_W - 1);
    localparam logic [14:0]       LAST_ROW = 15'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [14:0]       CNT_ONE  = 15'd1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              in_frame;

    // NOTE: in_ready is combinational from wr_ready so buffer back-pressure
    // stalls the producer in the same cycle, with no skid buffer needed.
    assign in_ready  = (state == WRITE) && wr_ready;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign in_frame  = (state == WRITE) || (state == ROW_GAP);
    assign first_row = in_frame && (row == 15'd0);
    assign last_row  = in_frame && (row == LAST_ROW);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            ptr        <= BASE;
            wr_en      <= 1'b0;
            wr_addr    <= BASE;
            wr_data    <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= accept;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                wr_addr <= ptr;
                wr_data <= in_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WRITE;
                        row   <= '0;
                        col   <= '0;
                        ptr   <= BASE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        // Address advances incrementally: BASE + row*IMG_W + col.
                        ptr <= ptr + ADDR_ONE;
                        if (col != LAST_COL) begin
                            col <= col + CNT_ONE;
                        end else if (row != LAST_ROW) begin
                            col      <= '0;
                            row      <= row + CNT_ONE;
                            row_done <= 1'b1;
                            state    <= ROW_GAP;
                        end else begin
                            col        <= '0;
                            row        <= '0;
                            row_done   <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                ROW_GAP: state <= WRITE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_writer.sv
// Self-checking bench: three writer configurations share one random stimulus
// stream and are each compared against a pixel-index reference model.
module tb_conv_row_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        wr_ready = 1'b0;
    logic [15:0] in_data = '0;

    always #5 clk = ~clk;

    logic [2:0]        rdy, wen, fr, lr, rd, fd, bsy;
    logic [2:0][18:0]  waddr;
    logic [2:0][15:0]  wdata;
    logic [2:0][14:0]  orow, ocol;

    conv_row_writer #(.IMG_W(4), .IMG_H(3), .BASE_ADDR(0)) u_4x3 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .wr_ready(wr_ready), .wr_en(wen[0]), .wr_addr(waddr[0]),
        .wr_data(wdata[0]), .row(orow[0]), .col(ocol[0]), .first_row(fr[0]),
        .last_row(lr[0]), .row_done(rd[0]), .frame_done(fd[0]), .busy(bsy[0]));

    conv_row_writer #(.IMG_W(4), .IMG_H(1), .BASE_ADDR(0)) u_4x1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .wr_ready(wr_ready), .wr_en(wen[1]), .wr_addr(waddr[1]),
        .wr_data(wdata[1]), .row(orow[1]), .col(ocol[1]), .first_row(fr[1]),
        .last_row(lr[1]), .row_done(rd[1]), .frame_done(fd[1]), .busy(bsy[1]));

    conv_row_writer #(.IMG_W(24), .IMG_H(20), .BASE_ADDR(1000)) u_24x20 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[2]), .wr_ready(wr_ready), .wr_en(wen[2]), .wr_addr(waddr[2]),
        .wr_data(wdata[2]), .row(orow[2]), .col(ocol[2]), .first_row(fr[2]),
        .last_row(lr[2]), .row_done(rd[2]), .frame_done(fd[2]), .busy(bsy[2]));

    int pw[3] = '{4, 4, 24};
    int ph[3] = '{3, 1, 20};
    int pb[3] = '{0, 0, 1000};

    // Reference model: frame progress is the count k of pixels accepted so far.
    bit          act[3], gap[3], dn[3];
    int          k[3];
    bit          e_wen[3], e_rd[3], e_fd[3];
    int          e_waddr[3];
    logic [15:0] e_wdata[3];

    int m_writes[3], m_frames[3], o_writes[3], o_frames[3], o_last_addr[3];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            act[i] = 0; gap[i] = 0; dn[i] = 0; k[i] = 0;
            e_wen[i] = 0; e_rd[i] = 0; e_fd[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            bit in_w;
            int r;
            in_w = act[i] && !gap[i] && !dn[i];
            r = k[i] / pw[i];
            check($sformatf("u%0d in_ready", i), rdy[i], in_w && wr_ready);
            check($sformatf("u%0d wr_en", i), wen[i], e_wen[i]);
            check($sformatf("u%0d busy", i), bsy[i], act[i]);
            check($sformatf("u%0d row", i), orow[i], r);
            check($sformatf("u%0d col", i), ocol[i], k[i] % pw[i]);
            check($sformatf("u%0d first_row", i), fr[i], act[i] && !dn[i] && r == 0);
            check($sformatf("u%0d last_row", i), lr[i], act[i] && !dn[i] && r == ph[i] - 1);
            check($sformatf("u%0d row_done", i), rd[i], e_rd[i]);
            check($sformatf("u%0d frame_done", i), fd[i], e_fd[i]);
            if (e_wen[i]) begin
                check($sformatf("u%0d wr_addr", i), waddr[i], e_waddr[i]);
                check($sformatf("u%0d wr_data", i), wdata[i], e_wdata[i]);
            end
            m_writes[i] += int'(e_wen[i]);
            m_frames[i] += int'(e_fd[i]);
            o_writes[i] += int'(wen[i]);
            o_frames[i] += int'(fd[i]);
            if (wen[i]) o_last_addr[i] = int'(waddr[i]);
        end
    endtask

    task automatic model_next();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = act[i] && !gap[i] && !dn[i] && wr_ready && in_valid;
            e_wen[i] = acc;
            e_rd[i]  = acc && ((k[i] + 1) % pw[i] == 0);
            e_fd[i]  = acc && (k[i] + 1 == pw[i] * ph[i]);
            if (acc) begin
                e_waddr[i] = pb[i] + k[i];
                e_wdata[i] = in_data;
            end
            if (!act[i]) begin
                if (start) begin act[i] = 1; k[i] = 0; end
            end else if (dn[i]) begin
                act[i] = 0; dn[i] = 0;
            end else if (gap[i]) begin
                gap[i] = 0;
            end else if (acc) begin
                k[i]++;
                if (k[i] == pw[i] * ph[i]) begin
                    dn[i] = 1; k[i] = 0;
                end else if (k[i] % pw[i] == 0) begin
                    gap[i] = 1;
                end
            end
        end
    endtask

    // Drive one cycle's inputs, compare at the falling edge, advance the model.
    task automatic cycle(input bit st, input bit v, input bit wr);
        start    = st;
        in_valid = v;
        wr_ready = wr;
        in_data  = 16'($urandom);
        @(negedge clk);
        check_all();
        model_next();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous stream; mode 1: wr_ready toggles, in_valid random.
    task automatic run_idle(input int mode, input int budget);
        int n;
        bit tog;
        n = 0;
        tog = 1;
        while ((act[0] || act[1] || act[2]) && n < budget) begin
            if (mode == 0) cycle(0, 1, 1);
            else           cycle(0, ($urandom % 3) != 0, tog);
            tog = !tog;
            n++;
        end
        check("idle_bound", n < budget, 1);
    endtask

    task automatic reset_state_checks();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d rst busy", i), bsy[i], 0);
            check($sformatf("u%0d rst row", i), orow[i], 0);
            check($sformatf("u%0d rst col", i), ocol[i], 0);
            check($sformatf("u%0d rst wr_en", i), wen[i], 0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            m_writes[i] = 0; m_frames[i] = 0; o_writes[i] = 0; o_frames[i] = 0;
            o_last_addr[i] = -1;
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) check($sformatf("u%0d rst wr_addr", i), waddr[i], pb[i]);
        @(posedge clk);
        #1 reset = 1'b0;

        // Continuous stream; start is pulsed in u4x1's DONE cycle and must be ignored.
        cycle(1, 1, 1);
        n = 0;
        while ((act[0] || act[1] || act[2]) && n < 2000) begin
            cycle(dn[1], 1, 1);
            n++;
        end
        check("stream_bound", n < 2000, 1);

        // Back-pressure: wr_ready alternates, in_valid randomly gated.
        cycle(1, 0, 0);
        run_idle(1, 6000);

        // Start mid-row 1 of the 4x3 frame is ignored; a later start from IDLE restarts.
        cycle(1, 1, 1);
        n = 0;
        while (k[0] < 5 && n < 50) begin cycle(0, 1, 1); n++; end
        cycle(1, 1, 1);
        run_idle(0, 2000);
        repeat (3) cycle(0, 0, 1);
        cycle(1, 0, 1);
        run_idle(0, 2000);

        // Asynchronous reset at row 2, col 2 of the 4x3 frame, then a fresh frame.
        cycle(1, 1, 1);
        n = 0;
        while (!(act[0] && !gap[0] && !dn[0] && k[0] == 10) && n < 50) begin
            cycle(0, 1, 1);
            n++;
        end
        check("reach_r2c2", n < 50, 1);
        reset = 1'b1;
        #1;
        reset_state_checks();
        model_reset();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) check($sformatf("u%0d rst2 wr_addr", i), waddr[i], pb[i]);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1, 1, 1);
        run_idle(0, 2000);
        repeat (2) cycle(0, 1, 1);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d total writes", i), o_writes[i], m_writes[i]);
            check($sformatf("u%0d total frames", i), o_frames[i], m_frames[i]);
            check($sformatf("u%0d last addr", i), o_last_addr[i], pb[i] + pw[i] * ph[i] - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
